// File: rtl/alien_fire_scheduler.sv
// rtl/alien_fire_scheduler.sv - invader shot scheduler: round-robin column pick, lowest free bullet slot,
// frame cooldown, one launch per frame with acknowledge/drop tracking.
module alien_fire_scheduler #(
    parameter int NUM_SHOOTERS = 11,
    parameter int NUM_SLOTS    = 3,
    parameter int SHOOTER_W    = 4,
    parameter int SLOT_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    enable,
    input  logic [7:0]              cooldown_frames,
    input  logic [NUM_SHOOTERS-1:0] req,
    input  logic [NUM_SLOTS-1:0]    slot_busy,
    output logic [NUM_SLOTS-1:0]    fire,
    output logic [SHOOTER_W-1:0]    fire_col,
    output logic [SLOT_W-1:0]       fire_slot,
    output logic                    dropped,
    output logic [15:0]             shots_fired
);

    localparam int CW = SHOOTER_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        ISSUE    = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t                 state_q;
    logic [NUM_SLOTS-1:0]   fire_q;
    logic [SHOOTER_W-1:0]   fire_col_q;
    logic [SLOT_W-1:0]      fire_slot_q;
    logic                   dropped_q;
    logic [15:0]            shots_q;
    logic [7:0]             cd_cnt_q;
    logic [SHOOTER_W-1:0]   rr_ptr_q;

    logic [SHOOTER_W-1:0]   win_col_d;
    logic [SLOT_W-1:0]      win_slot_d;
    logic                   col_found;
    logic [CW-1:0]          col_idx;

    // Rotating search starting at rr_ptr; the index stays one bit wider so the wrap never overflows.
    always_comb begin
        win_col_d = '0;
        col_found = 1'b0;
        col_idx   = '0;
        for (int k = 0; k < NUM_SHOOTERS; k++) begin
            col_idx = {1'b0, rr_ptr_q} + CW'(k);
            if (col_idx >= CW'(NUM_SHOOTERS)) begin
                col_idx = col_idx - CW'(NUM_SHOOTERS);
            end
            if (!col_found && req[col_idx[SHOOTER_W-1:0]]) begin
                col_found = 1'b1;
                win_col_d = col_idx[SHOOTER_W-1:0];
            end
        end
    end

    always_comb begin
        win_slot_d = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!slot_busy[SLOT_W'(s)]) begin
                win_slot_d = SLOT_W'(s);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fire_q      <= '0;
            fire_col_q  <= '0;
            fire_slot_q <= '0;
            dropped_q   <= 1'b0;
            shots_q     <= '0;
            cd_cnt_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            fire_q    <= '0;
            dropped_q <= 1'b0;
            if (frame && cd_cnt_q != 8'd0) begin
                cd_cnt_q <= cd_cnt_q - 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (enable && cd_cnt_q == 8'd0) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (frame && col_found && !(&slot_busy)) begin
                        fire_q      <= NUM_SLOTS'(1) << win_slot_d;
                        fire_col_q  <= win_col_d;
                        fire_slot_q <= win_slot_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Placed after the frame decrement so the cooldown load takes priority.
                    cd_cnt_q <= cooldown_frames;
                    rr_ptr_q <= (fire_col_q == SHOOTER_W'(NUM_SHOOTERS - 1)) ? '0 : fire_col_q + 1'b1;
                    state_q  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (slot_busy[fire_slot_q]) begin
                        shots_q <= shots_q + 16'd1;
                        state_q <= IDLE;
                    end else if (frame) begin
                        dropped_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fire        = fire_q;
    assign fire_col    = fire_col_q;
    assign fire_slot   = fire_slot_q;
    assign dropped     = dropped_q;
    assign shots_fired = shots_q;

endmodule

// File: tb/tb_alien_fire_scheduler.sv
// tb/tb_alien_fire_scheduler.sv - frame-level reference model with directed and random scheduler scenarios.
module tb_alien_fire_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame;
    logic        enable;
    logic [7:0]  cooldown_frames;
    logic [10:0] req;
    logic [2:0]  slot_busy;
    logic [2:0]  fire;
    logic [3:0]  fire_col;
    logic [1:0]  fire_slot;
    logic        dropped;
    logic [15:0] shots_fired;

    alien_fire_scheduler #(
        .NUM_SHOOTERS(11), .NUM_SLOTS(3), .SHOOTER_W(4), .SLOT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .enable(enable),
        .cooldown_frames(cooldown_frames), .req(req), .slot_busy(slot_busy),
        .fire(fire), .fire_col(fire_col), .fire_slot(fire_slot),
        .dropped(dropped), .shots_fired(shots_fired)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Model state, one update per frame transaction
    int   m_cd, m_rr, m_col, m_slot, m_pslot;
    bit   m_pend;
    int   m_shots;
    bit   g_fired;
    logic [8:0] fired_mask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_col(input logic [10:0] rq, input int rr);
        for (int k = 0; k < 11; k++) begin
            if (rq[(rr + k) % 11]) return (rr + k) % 11;
        end
        return -1;
    endfunction

    function automatic int lowest_free(input logic [2:0] bz);
        for (int s = 0; s < 3; s++) begin
            if (!bz[s]) return s;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; frame = 1'b0; enable = 1'b0; req = '0; slot_busy = '0; cooldown_frames = '0;
        @(negedge clk);
        check("rst_fire", fire, 0);
        check("rst_col", fire_col, 0);
        check("rst_slot", fire_slot, 0);
        check("rst_dropped", dropped, 0);
        check("rst_shots", shots_fired, 0);
        rst = 1'b0;
        m_cd = 0; m_rr = 0; m_col = 0; m_slot = 0; m_pslot = 0; m_pend = 0; m_shots = 0;
    endtask

    // One frame period: setup inputs, two settle cycles, frame pulse, then post-launch cycles.
    task automatic run_period(input bit en, input logic [10:0] rq, input logic [2:0] bz,
                              input logic [7:0] cool, input bit ack, input bit ack_at_frame);
        bit armed, launch, exp_drop;
        @(negedge clk);
        enable = en; req = rq; slot_busy = bz; cooldown_frames = cool;
        if (m_pend && bz[m_pslot]) begin
            m_shots++;
            m_pend = 0;
        end
        armed = en && !m_pend && (m_cd == 0);
        @(negedge clk);
        @(negedge clk);
        frame = 1'b1;
        exp_drop = 0;
        if (m_pend && ack_at_frame) begin
            slot_busy[m_pslot] = 1'b1;
            m_shots++;
        end else begin
            exp_drop = m_pend;
        end
        m_pend = 0;
        launch = armed && (rq != 0) && (bz != 3'b111);
        if (m_cd > 0) m_cd--;
        if (launch) begin
            m_col   = next_col(rq, m_rr);
            m_slot  = lowest_free(bz);
            m_rr    = (m_col + 1) % 11;
            m_cd    = cool;
            m_pend  = 1;
            m_pslot = m_slot;
        end
        @(negedge clk);
        frame = 1'b0;
        g_fired = (fire != 0);
        check("fire", fire, launch ? (32'd1 << m_slot) : 32'd0);
        check("fire_col", fire_col, m_col);
        check("fire_slot", fire_slot, m_slot);
        check("dropped_at_frame", dropped, exp_drop);
        check("shots_at_frame", shots_fired, m_shots[15:0]);
        if (launch && ack) begin
            slot_busy[m_slot] = 1'b1;
            m_shots++;
            m_pend = 0;
        end
        repeat (3) @(negedge clk);
        check("fire_after", fire, 0);
        check("dropped_after", dropped, 0);
        check("shots_after", shots_fired, m_shots[15:0]);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; frame = 1'b0; enable = 1'b0; req = '0; slot_busy = '0; cooldown_frames = '0;

        // Single column, single shot
        do_reset();
        run_period(1, 11'h001, 3'b000, 8'd0, 1, 0);
        check("t1_fire", fire, 0);
        check("t1_col", fire_col, 0);

        // Full round robin: 0..10 then wrap to 0
        do_reset();
        for (int i = 0; i < 12; i++) begin
            run_period(1, 11'h7FF, 3'b000, 8'd0, 1, 0);
            check("t2_rr_col", fire_col, i % 11);
        end

        // Slot selection and all-busy stall
        do_reset();
        run_period(1, 11'h7FF, 3'b011, 8'd0, 1, 0);
        check("t3_slot2", fire_slot, 2);
        run_period(1, 11'h7FF, 3'b111, 8'd0, 0, 0);
        check("t3_nofire", g_fired, 0);
        run_period(1, 11'h7FF, 3'b000, 8'd0, 1, 0);
        check("t3_resume", g_fired, 1);

        // Cooldown of three frames
        do_reset();
        fired_mask = '0;
        for (int i = 0; i < 9; i++) begin
            run_period(1, 11'h7FF, 3'b000, 8'd3, 1, 0);
            fired_mask[i] = g_fired;
        end
        check("t4_launch_frames", fired_mask, 9'b100010001);

        // Drop, then ack coinciding with frame
        do_reset();
        run_period(1, 11'h020, 3'b000, 8'd0, 0, 0);
        run_period(1, 11'h020, 3'b000, 8'd0, 0, 0);
        run_period(1, 11'h020, 3'b000, 8'd0, 1, 0);
        run_period(1, 11'h020, 3'b000, 8'd0, 0, 0);
        run_period(1, 11'h020, 3'b000, 8'd0, 0, 1);

        // Reset while waiting for ack, then enable low for five frames
        run_period(1, 11'h7FF, 3'b000, 8'd0, 0, 0);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_period(0, 11'h7FF, 3'b000, 8'd0, 1, 0);
        end

        // Randomised frames against the model
        for (int i = 0; i < 80; i++) begin
            run_period(($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 5) == 0) ? 11'h000 : 11'($urandom),
                       3'($urandom),
                       8'($urandom_range(0, 2)),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
